argo_chan_reader: RTL and testbench

// - Downstream consumer stage for an argo_fifo channel.
// - Drains the FIFO (rd_en / rd_data, 1-cycle read latency) and presents the words as a registered valid/ready stream to the next dataflow stage.
// - A 2-entry output buffer plus in-flight tracking gives 1 word/cycle sustained throughput and absorbs consumer back-pressure without losing words.

---
 rtl/argo_chan_reader.sv | 112 +++++++++++
 tb/tb_argo_chan_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/argo_chan_reader.sv
// argo_chan_reader: drains an argo_fifo channel into a registered valid/ready stream.
// Optional transfer counter enabled by defining ARGO_CHAN_READER_COUNT_EN.
module argo_chan_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef ARGO_CHAN_READER_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

    // State encoding doubles as the buffer occupancy count.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    if (DATA_WIDTH == 0 || CNT_WIDTH == 0) begin : g_bad_param
        $error("argo_chan_reader: DATA_WIDTH and CNT_WIDTH must be non-zero");
    end

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ent1;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] ent1_next;
    logic                  pop;
    logic                  push;
    logic [2:0]            level;

    assign pop  = out_valid & out_ready;
    assign push = inflight;

    // Occupancy after this edge if no new read were issued.
    assign level = 3'(state) + 3'(inflight) - 3'(pop);

    assign fifo_rd_en = rst & ~fifo_empty & (level < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_EMPTY;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ent1      <= '0;
        end else begin
            state     <= state_next;
            inflight  <= fifo_rd_en;
            out_valid <= (state_next != S_EMPTY);
            out_data  <= head_next;
            ent1      <= ent1_next;
        end
    end

    // Next-state and buffer datapath; out_data is the head entry.
    always_comb begin
        state_next = state;
        head_next  = out_data;
        ent1_next  = ent1;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    head_next  = fifo_rd_data;
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                case ({push, pop})
                    2'b11: head_next = fifo_rd_data;
                    2'b10: begin
                        ent1_next  = fifo_rd_data;
                        state_next = S_TWO;
                    end
                    2'b01: state_next = S_EMPTY;
                    default: ;
                endcase
            end
            S_TWO: begin
                // push without pop cannot occur here: issue is gated at occupancy 2
                if (pop) begin
                    head_next = ent1;
                    if (push) begin
                        ent1_next = fifo_rd_data;
                    end else begin
                        state_next = S_ONE;
                    end
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

`ifdef ARGO_CHAN_READER_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
// Directed bench for argo_chan_reader with a behavioural FIFO and an expected-word scoreboard.
module tb_argo_chan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef ARGO_CHAN_READER_COUNT_EN
    logic [31:0] xfer_count;
`endif

    argo_chan_reader #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
`ifdef ARGO_CHAN_READER_COUNT_EN
        ,
        .xfer_count   (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int issued = 0;
    int popped = 0;
    int pops_since_rst = 0;
    bit last_pop;
    bit last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample handshakes, score pops, advance the FIFO model.
    task automatic step();
        bit rd;
        bit pp;
        logic [31:0] e;
        #1;
        rd = fifo_rd_en;
        pp = out_valid && out_ready;
        if (rd) check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        if (pp) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_pop observed=%0h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                tests--;
                check("out_data_order", out_data, e);
            end
            popped++;
            pops_since_rst++;
        end
        if (rd) issued++;
        check("occ_plus_inflight_le2", 32'(issued - popped > 2), 32'd0);
        last_rd  = rd;
        last_pop = pp;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_count(input string tag);
`ifdef ARGO_CHAN_READER_COUNT_EN
        check(tag, xfer_count, 32'(pops_since_rst));
`else
        check(tag, 32'(popped - pops_since_rst >= 0), 32'd1);
`endif
    endtask

    initial begin
        int rd_cnt;
        int first_pop;
        int last_pop_cyc;
        int cyc;
        int sent;
        int t6_pops;

        // T1 reset / idle
        rst = 1'b0;
        fifo_empty = 1'b1;
        out_ready = 1'b0;
        fifo_rd_data = 32'd0;
        @(negedge clk);
        #1;
        check("t1_valid_in_reset", 32'(out_valid), 32'd0);
        check("t1_rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        check("t1_data_in_reset", out_data, 32'd0);
        check_count("t1_count_in_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_idle_no_rd", 32'(last_rd), 32'd0);
            check("t1_idle_no_valid", 32'(out_valid), 32'd0);
        end

        // T2 single word: rd at N, valid at N+2, drop at N+3
        out_ready = 1'b1;
        load(32'h0000_00A5);
        #1;
        check("t2_rd_en_N", 32'(fifo_rd_en), 32'd1);
        step();
        #1;
        check("t2_rd_en_N1", 32'(fifo_rd_en), 32'd0);
        check("t2_valid_N1", 32'(out_valid), 32'd0);
        step();
        #1;
        check("t2_valid_N2", 32'(out_valid), 32'd1);
        check("t2_data_N2", out_data, 32'h0000_00A5);
        step();
        #1;
        check("t2_valid_N3", 32'(out_valid), 32'd0);

        // T3 streaming 1..8 at one word per cycle
        for (int i = 1; i <= 8; i++) load(32'(i));
        first_pop = -1;
        last_pop_cyc = -1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 30) begin
            step();
            if (last_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop_cyc = cyc;
            end
            cyc++;
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_pop_span", 32'(last_pop_cyc - first_pop + 1), 32'd8);
        check_count("t3_xfer_count");
        step();
        #1;
        check("t3_valid_after", 32'(out_valid), 32'd0);

        // T4 back-pressure: two reads then hold head stable
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(32'(i));
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_rd) rd_cnt++;
            if (out_valid) check("t4_head_hold", out_data, 32'd1);
        end
        check("t4_stall_rd_pulses", 32'(rd_cnt), 32'd2);
        check("t4_valid_stalled", 32'(out_valid), 32'd1);
        check("t4_data_stalled", out_data, 32'd1);
        out_ready = 1'b1;
        drain("t4_drained", 30);
        check_count("t4_xfer_count");

        // T5 toggling ready with refilling writer
        sent = 0;
        cyc = 0;
        while ((sent < 16 || exp_q.size() > 0) && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            if (sent < 16 && fifo_q.size() < 2) begin
                load(32'(100 + sent));
                sent++;
            end
            step();
            cyc++;
        end
        check("t5_all_sent", 32'(sent), 32'd16);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check_count("t5_xfer_count");

        // T6 reset after 3 of 8 words popped
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(32'(200 + i));
        t6_pops = 0;
        cyc = 0;
        while (t6_pops < 3 && cyc < 30) begin
            step();
            if (last_pop) t6_pops++;
            cyc++;
        end
        check("t6_three_popped", 32'(t6_pops), 32'd3);
        rst = 1'b0;
        #1;
        check("t6_valid_async", 32'(out_valid), 32'd0);
        check("t6_rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        check("t6_data_in_reset", out_data, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        issued = 0;
        popped = 0;
        pops_since_rst = 0;
        check_count("t6_count_in_reset");
        step();
        rst = 1'b1;
        step();
        check("t6_idle_after", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) load(32'(300 + i));
        drain("t6_restart_drained", 20);
        check_count("t6_xfer_count");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
